tick_generator_bank: RTL and testbench



---
 rtl/tick_generator_bank_pkg.sv | 20 ++
 rtl/tick_generator_bank_channel.sv | 73 +++++++
 rtl/tick_generator_bank.sv | 78 +++++++
 tb/tb_tick_generator_bank.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/tick_generator_bank_pkg.sv
// Shared definitions for the tick generator bank: channel-select width, divisor clamp, mode encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tick_gen_defs;

    // Smallest effective divisor; a programmed divisor of 0 behaves as this value.
    localparam int DIV_MIN = 1;

    // Channel run mode.
    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

    // Width of the channel-select field; never less than one bit so a single-channel bank still has a port.
    function automatic int ch_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/tick_generator_bank_channel.sv
// One programmable channel: counts base ticks and pulses tick / toggles level when the divisor expires.
// Latency: tick and level change 1 clk after the expiring base tick; config writes take effect next clk.
// Backpressure: none; a write is accepted every cycle and overrides a coincident expiry.
module tick_channel
    import tick_gen_defs::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(1000000),
    parameter logic             DEFAULT_EN  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             base_tick,
    input  logic             wr,
    input  logic [WIDTH-1:0] div_in,
    input  logic             en_in,
    input  logic             oneshot_in,
    output logic             tick,
    output logic             level,
    output logic             active
);

    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_cnt;
    logic             r_en;
    mode_e            r_mode;
    logic             r_tick;
    logic             r_level;

    logic [WIDTH-1:0] w_last;
    logic             w_expire;

    // Terminal count is div-1, with div=0 clamped to DIV_MIN so the counter can never run past it.
    assign w_last   = (r_div > WIDTH'(DIV_MIN)) ? (r_div - WIDTH'(DIV_MIN)) : '0;
    assign w_expire = (r_cnt == w_last);

    // Channel state: a config write wins over everything except reset, including an expiry on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_div   <= DEFAULT_DIV;
            r_en    <= DEFAULT_EN;
            r_mode  <= MODE_PERIODIC;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_level <= 1'b0;
        end else if (wr) begin
            r_div   <= div_in;
            r_en    <= en_in;
            r_mode  <= oneshot_in ? MODE_ONESHOT : MODE_PERIODIC;
            r_cnt   <= '0;
            r_tick  <= 1'b0;
        end else if (base_tick && r_en) begin
            if (w_expire) begin
                r_cnt   <= '0;
                r_tick  <= 1'b1;
                r_level <= ~r_level;
                if (r_mode == MODE_ONESHOT) begin
                    r_en <= 1'b0;
                end
            end else begin
                r_cnt  <= r_cnt + WIDTH'(1);
                r_tick <= 1'b0;
            end
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign tick   = r_tick;
    assign level  = r_level;
    assign active = r_en;

endmodule

// File: rtl/tick_generator_bank.sv
// Bank of runtime-programmable tick generators sharing one free-running base-tick prescaler.
// Latency: base_tick 1 clk after prescaler wrap; channel tick 1 clk after its expiring base tick.
// Backpressure: none; config writes accepted every cycle, writes to nonexistent channels are dropped.
module tick_generator_bank
    import tick_gen_defs::*;
#(
    parameter int                  CHANNELS    = 4,
    parameter int                  WIDTH       = 32,
    parameter int                  PRESCALE    = 100,
    parameter longint              DEFAULT_DIV = 1000000,
    parameter logic [CHANNELS-1:0] DEFAULT_EN  = '0,
    localparam int                 CH_W        = ch_width(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [WIDTH-1:0]    cfg_div,
    input  logic                cfg_en,
    input  logic                cfg_oneshot,
    output logic                base_tick,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] active
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0]    r_pre_cnt;
    logic                r_base_tick;
    logic                w_pre_wrap;
    logic [CHANNELS-1:0] w_wr;

    assign w_pre_wrap = (r_pre_cnt == PRE_W'(PRESCALE - 1));

    // Free-running prescaler; base_tick is registered so it lands the cycle after the wrap count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pre_cnt   <= '0;
            r_base_tick <= 1'b0;
        end else begin
            r_base_tick <= w_pre_wrap;
            r_pre_cnt   <= w_pre_wrap ? '0 : (r_pre_cnt + PRE_W'(1));
        end
    end

    assign base_tick = r_base_tick;

    // Decode the write strobe; selects at or beyond CHANNELS match nothing and are silently ignored.
    always_comb begin
        w_wr = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_we && (cfg_ch == CH_W'(i))) begin
                w_wr[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        tick_channel #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (WIDTH'(DEFAULT_DIV)),
            .DEFAULT_EN  (DEFAULT_EN[g])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .base_tick  (r_base_tick),
            .wr         (w_wr[g]),
            .div_in     (cfg_div),
            .en_in      (cfg_en),
            .oneshot_in (cfg_oneshot),
            .tick       (tick[g]),
            .level      (level[g]),
            .active     (active[g])
        );
    end

endmodule

// File: tb/tb_tick_generator_bank.sv
// Bench for tick_generator_bank: a schedule-based reference model predicts every cycle's outputs,
// a monitor compares them against a 4-channel DUT and a 3-channel DUT fed the same config stream.
// Writes to channel 3 must reach only the 4-channel instance.
module tb_tick_generator_bank;

    localparam int P   = 4;
    localparam int NCH = 4;
    localparam int W   = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_ch = '0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_en = 1'b0;
    logic         cfg_oneshot = 1'b0;

    logic         bt4, bt3;
    logic [3:0]   tick4, level4, active4;
    logic [2:0]   tick3, level3, active3;

    tick_generator_bank #(
        .CHANNELS(4), .WIDTH(W), .PRESCALE(P), .DEFAULT_DIV(10), .DEFAULT_EN(4'b0000)
    ) u_dut4 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_en(cfg_en), .cfg_oneshot(cfg_oneshot), .base_tick(bt4),
        .tick(tick4), .level(level4), .active(active4)
    );

    tick_generator_bank #(
        .CHANNELS(3), .WIDTH(W), .PRESCALE(P), .DEFAULT_DIV(10), .DEFAULT_EN(3'b000)
    ) u_dut3 (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
        .cfg_en(cfg_en), .cfg_oneshot(cfg_oneshot), .base_tick(bt3),
        .tick(tick3), .level(level3), .active(active3)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       bt;
        logic [3:0] tk;
        logic [3:0] lv;
        logic [3:0] ac;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int errors = 0;
    int checks = 0;
    int gc = 0;     // rising edges since time zero
    int r0 = 0;     // edge index of the most recent reset edge (cycle 0 of the epoch)

    // Reference state: per channel an enable, mode, level and the absolute edge of its next tick.
    bit m_en[NCH];
    bit m_os[NCH];
    bit m_lv[NCH];
    int m_next[NCH];
    int m_per[NCH];

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s cycle=%0d got=%b expected=%b", nm, gc - r0, act, exp);
        end
    endtask

    // Advance the reference across one rising edge using the inputs that were present before it.
    task automatic model_edge();
        exp_t e;
        int   d;
        int   w;
        e = '0;
        if (rst) begin
            r0 = gc;
            for (int c = 0; c < NCH; c++) begin
                m_en[c] = 1'b0;
                m_os[c] = 1'b0;
                m_lv[c] = 1'b0;
            end
        end else begin
            if (cfg_we && (int'(cfg_ch) < NCH)) begin
                d = (cfg_div == 0) ? 1 : int'(cfg_div);
                w = gc - 1;
                m_en[cfg_ch]   = cfg_en;
                m_os[cfg_ch]   = cfg_oneshot;
                m_per[cfg_ch]  = d * P;
                // D-th base tick strictly after the write cycle, plus one clk of output latency.
                m_next[cfg_ch] = r0 + ((w - r0) / P + d) * P + 1;
            end
            e.bt = ((gc - r0) >= P) && (((gc - r0) % P) == 0);
            for (int c = 0; c < NCH; c++) begin
                if (m_en[c] && (m_next[c] == gc)) begin
                    e.tk[c] = 1'b1;
                    m_lv[c] = !m_lv[c];
                    if (m_os[c]) m_en[c] = 1'b0;
                    else         m_next[c] = m_next[c] + m_per[c];
                end
            end
        end
        for (int c = 0; c < NCH; c++) begin
            e.lv[c] = m_lv[c];
            e.ac[c] = m_en[c];
        end
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        gc++;
        model_edge();
        #1;
        cfg_we = 1'b0;
        rst    = 1'b0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [W-1:0] div, input logic en, input logic os);
        cfg_we      = 1'b1;
        cfg_ch      = ch;
        cfg_div     = div;
        cfg_en      = en;
        cfg_oneshot = os;
    endtask

    task automatic run_to(input int n);
        while ((gc - r0) < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
    endtask

    // Monitor: pops one expectation per cycle and compares both instances away from the active edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("base_tick",   {3'b000, bt4},   {3'b000, mon_e.bt});
            chk("tick",        tick4,           mon_e.tk);
            chk("level",       level4,          mon_e.lv);
            chk("active",      active4,         mon_e.ac);
            chk("base_tick_3", {3'b000, bt3},   {3'b000, mon_e.bt});
            chk("tick_3",      {1'b0, tick3},   {1'b0, mon_e.tk[2:0]});
            chk("level_3",     {1'b0, level3},  {1'b0, mon_e.lv[2:0]});
            chk("active_3",    {1'b0, active3}, {1'b0, mon_e.ac[2:0]});
        end
    end

    initial begin
        // Power-up reset, then 100 idle cycles: only base_tick may move.
        step();
        run_to(100);

        // Periodic div=3, one-shot div=2, div=0 clamp, and a full-range divisor on channel 3.
        do_reset();
        wr(2'd0, 8'd3, 1'b1, 1'b0);   step();
        wr(2'd1, 8'd2, 1'b1, 1'b1);   step();
        wr(2'd2, 8'd0, 1'b1, 1'b0);   step();
        wr(2'd3, 8'd255, 1'b1, 1'b0); step();
        run_to(1100);

        // Rewrite on the expiry edge: the pending tick is dropped and counting restarts.
        do_reset();
        wr(2'd0, 8'd3, 1'b1, 1'b0);
        run_to(12);
        wr(2'd0, 8'd5, 1'b1, 1'b0);
        run_to(60);

        // Reset while channels are running.
        do_reset();
        wr(2'd0, 8'd1, 1'b1, 1'b0); step();
        wr(2'd1, 8'd3, 1'b1, 1'b0);
        run_to(10);
        rst = 1'b1;
        step();
        run_to(20);

        // Random config traffic with occasional resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 399) == 0) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 4) == 0) begin
                wr(2'($urandom_range(0, 3)), 8'($urandom_range(0, 6)),
                   1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            end
            step();
        end

        step();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d pending expected=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
